// File: rtl/tmds_pkg.sv
// ============================================================================
// tmds_pkg : shared TMDS control tokens, types and symbol decode helpers
// Revision : 1.0
// ============================================================================
`default_nettype none

package tmds_pkg;

  localparam logic [9:0] C_TOK_00 = 10'b1101010100;
  localparam logic [9:0] C_TOK_01 = 10'b0010101011;
  localparam logic [9:0] C_TOK_10 = 10'b0101010100;
  localparam logic [9:0] C_TOK_11 = 10'b1010101011;

  typedef logic [1:0] tok_code_t;

  typedef enum logic {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } align_state_t;

  typedef struct packed {
    logic      hit;
    tok_code_t code;
  } tok_match_t;

  function automatic tok_match_t tmds_token_match(input logic [9:0] sym);
    tok_match_t m;
    m.hit  = 1'b1;
    m.code = 2'd0;
    case (sym)
      C_TOK_00: m.code = 2'd0;
      C_TOK_01: m.code = 2'd1;
      C_TOK_10: m.code = 2'd2;
      C_TOK_11: m.code = 2'd3;
      default:  m.hit  = 1'b0;
    endcase
    return m;
  endfunction

  // Undo the transition-minimising stage: bit 9 = inverted, bit 8 = XOR vs XNOR chain.
  function automatic logic [7:0] tmds_decode(input logic [9:0] sym);
    logic [7:0] d;
    logic [7:0] v;
    d    = sym[9] ? ~sym[7:0] : sym[7:0];
    v[0] = d[0];
    for (int i = 1; i < 8; i++) begin
      v[i] = sym[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
    end
    return v;
  endfunction

endpackage

`default_nettype wire

// File: rtl/tmds_word_aligner.sv
// ============================================================================
// tmds_word_aligner : bit-slip symbol alignment driven by control-token runs
// Revision : 1.0
// ============================================================================
`default_nettype none

module tmds_word_aligner
  import tmds_pkg::*;
#(
  parameter int TOKEN_RUN      = 8,
  parameter int SEARCH_TIMEOUT = 4096,
  parameter int LOSS_TIMEOUT   = 8192
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] i_raw,
  output logic [9:0] o_win,
  output logic       o_locked,
  output logic [3:0] o_offset
);

  localparam int TMR_SPAN = (SEARCH_TIMEOUT > LOSS_TIMEOUT) ? SEARCH_TIMEOUT : LOSS_TIMEOUT;
  localparam int RUN_W    = $clog2(TOKEN_RUN + 1);
  localparam int TMR_W    = $clog2(TMR_SPAN);

  localparam logic [RUN_W-1:0] RUN_FULL    = RUN_W'(TOKEN_RUN);
  localparam logic [TMR_W-1:0] SEARCH_LAST = TMR_W'(SEARCH_TIMEOUT - 1);
  localparam logic [TMR_W-1:0] LOSS_LAST   = TMR_W'(LOSS_TIMEOUT - 1);

  align_state_t     r_state;
  logic [9:0]       r_prev;
  logic [9:0]       r_win;
  logic [RUN_W-1:0] r_run;
  logic [TMR_W-1:0] r_tmr;
  logic [3:0]       r_offset;
  logic             r_locked;

  logic [19:0]      w_shift;
  logic             w_tok;
  logic [RUN_W-1:0] w_run_nxt;
  logic             w_run_full;
  logic [3:0]       w_offset_nxt;

  // Both words are always present, so any offset 0..9 sees a complete symbol.
  assign w_shift      = {i_raw, r_prev} >> r_offset;
  assign w_tok        = tmds_token_match(r_win).hit;
  assign w_run_nxt    = w_tok ? ((r_run == RUN_FULL) ? r_run : r_run + 1'b1) : '0;
  assign w_run_full   = (w_run_nxt == RUN_FULL);
  assign w_offset_nxt = (r_offset == 4'd9) ? 4'd0 : r_offset + 4'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= SEARCH;
      r_prev   <= '0;
      r_win    <= '0;
      r_run    <= '0;
      r_tmr    <= '0;
      r_offset <= '0;
      r_locked <= 1'b0;
    end else begin
      r_prev <= i_raw;
      r_win  <= w_shift[9:0];
      r_run  <= w_run_nxt;
      case (r_state)
        SEARCH: begin
          if (w_run_full) begin
            r_state  <= LOCKED;
            r_locked <= 1'b1;
            r_tmr    <= '0;
          end else if (r_tmr == SEARCH_LAST) begin
            r_offset <= w_offset_nxt;
            r_tmr    <= '0;
            r_run    <= '0;
          end else begin
            r_tmr <= r_tmr + 1'b1;
          end
        end
        LOCKED: begin
          if (w_run_full) begin
            r_tmr <= '0;
          end else if (r_tmr == LOSS_LAST) begin
            r_state  <= SEARCH;
            r_locked <= 1'b0;
            r_offset <= w_offset_nxt;
            r_tmr    <= '0;
            r_run    <= '0;
          end else begin
            r_tmr <= r_tmr + 1'b1;
          end
        end
      endcase
    end
  end

  assign o_win    = r_win;
  assign o_locked = r_locked;
  assign o_offset = r_offset;

endmodule

`default_nettype wire

// File: rtl/tmds_channel_decoder.sv
// ============================================================================
// tmds_channel_decoder : one TMDS receive channel, alignment plus symbol decode
// Revision : 1.0
// ============================================================================
`default_nettype none

module tmds_channel_decoder
  import tmds_pkg::*;
#(
  parameter int TOKEN_RUN      = 8,
  parameter int SEARCH_TIMEOUT = 4096,
  parameter int LOSS_TIMEOUT   = 8192
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] raw_in,
  output logic [7:0] vd,
  output logic [1:0] cd,
  output logic       vde,
  output logic       locked,
  output logic [3:0] offset
);

  logic [9:0] w_win;
  tok_match_t w_match;
  logic [7:0] r_vd;
  logic [1:0] r_cd;
  logic       r_vde;

  tmds_word_aligner #(
    .TOKEN_RUN      (TOKEN_RUN),
    .SEARCH_TIMEOUT (SEARCH_TIMEOUT),
    .LOSS_TIMEOUT   (LOSS_TIMEOUT)
  ) u_aligner (
    .clk      (clk),
    .rst      (rst),
    .i_raw    (raw_in),
    .o_win    (w_win),
    .o_locked (locked),
    .o_offset (offset)
  );

  assign w_match = tmds_token_match(w_win);

  // cd is sticky across data periods so it always reports the last token seen.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vd  <= '0;
      r_cd  <= '0;
      r_vde <= 1'b0;
    end else if (w_match.hit) begin
      r_vd  <= '0;
      r_cd  <= w_match.code;
      r_vde <= 1'b0;
    end else begin
      r_vd  <= tmds_decode(w_win);
      r_vde <= 1'b1;
    end
  end

  assign vd  = r_vd;
  assign cd  = r_cd;
  assign vde = r_vde;

endmodule

`default_nettype wire

// File: tb/tb_tmds_channel_decoder.sv
// ============================================================================
// tb_tmds_channel_decoder : directed vectors and alignment sequences for the decoder
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_tmds_channel_decoder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [9:0] raw_in = '0;
  logic [7:0] vd;
  logic [1:0] cd;
  logic       vde;
  logic       locked;
  logic [3:0] offset;

  int n_vec = 0;
  int n_err = 0;
  int k_word = 0;
  int mode = 0;
  int stream_sh = 0;

  typedef struct {
    logic [9:0] raw;
    logic [7:0] vd;
    logic [1:0] cd;
    logic       vde;
  } vec_t;

  vec_t tbl[13];

  tmds_channel_decoder dut (
    .clk    (clk),
    .rst    (rst),
    .raw_in (raw_in),
    .vd     (vd),
    .cd     (cd),
    .vde    (vde),
    .locked (locked),
    .offset (offset)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Video lines of 1000 symbols: 200 blanking tokens (code 01) then 800 data words.
  function automatic logic [9:0] line_sym(input int n);
    return ((n % 1000) < 200) ? 10'b0010101011 : 10'b0100001111;
  endfunction

  // Deserializer word k whose first bit lies sh bits before a symbol boundary.
  function automatic logic [9:0] stream_word(input int k, input int sh);
    logic [9:0] w;
    logic [9:0] s;
    int p;
    w = '0;
    for (int j = 0; j < 10; j++) begin
      p = 10 * k + j + ((10 - sh) % 10);
      s = line_sym(p / 10);
      w[j] = s[p % 10];
    end
    return w;
  endfunction

  function automatic logic [9:0] gen_word(input int m, input int k, input int sh);
    case (m)
      1:       return stream_word(k, sh);
      2:       return (k >= 4086 && k <= 4099) ? 10'b1010101011 : 10'b0100001111;
      3:       return (k < 16) ? 10'b1101010100 : 10'b1111111111;
      4:       return (k < 36864) ? 10'b1111111111 : stream_word(k, 0);
      default: return 10'b1111111111;
    endcase
  endfunction

  task automatic drive_tick();
    raw_in = gen_word(mode, k_word, stream_sh);
    k_word++;
    tick();
  endtask

  task automatic run_to(input int target);
    while (k_word < target) drive_tick();
  endtask

  task automatic do_reset(input int m, input int sh);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    k_word = 0;
    mode = m;
    stream_sh = sh;
  endtask

  task automatic wait_locked(input logic want, input int budget, input string name);
    int n;
    n = 0;
    while (locked !== want && n < budget) begin
      drive_tick();
      n++;
    end
    check(name, 32'(locked), 32'(want));
  endtask

  initial begin
    int d;

    tbl[0]  = '{10'b1101010100, 8'h00, 2'd0, 1'b0};
    tbl[1]  = '{10'b1111111111, 8'h00, 2'd0, 1'b1};
    tbl[2]  = '{10'b0010101011, 8'h00, 2'd1, 1'b0};
    tbl[3]  = '{10'b0000000000, 8'hFE, 2'd1, 1'b1};
    tbl[4]  = '{10'b0100000001, 8'h03, 2'd1, 1'b1};
    tbl[5]  = '{10'b0101010100, 8'h00, 2'd2, 1'b0};
    tbl[6]  = '{10'b0111111111, 8'h01, 2'd2, 1'b1};
    tbl[7]  = '{10'b1000000000, 8'hFF, 2'd2, 1'b1};
    tbl[8]  = '{10'b1010101011, 8'h00, 2'd3, 1'b0};
    tbl[9]  = '{10'b0010101010, 8'h00, 2'd3, 1'b1};
    tbl[10] = '{10'b0101010101, 8'hFF, 2'd3, 1'b1};
    tbl[11] = '{10'b0100001111, 8'h11, 2'd3, 1'b1};
    tbl[12] = '{10'b0100000000, 8'h00, 2'd3, 1'b1};

    // Reset held with random input.
    for (int i = 0; i < 5; i++) begin
      raw_in = 10'($urandom);
      tick();
    end
    check("rst_vd", 32'(vd), 0);
    check("rst_cd", 32'(cd), 0);
    check("rst_vde", 32'(vde), 0);
    check("rst_locked", 32'(locked), 0);
    check("rst_offset", 32'(offset), 0);

    // Symbol decode table; each word is held so the offset-0 window equals it.
    do_reset(0, 0);
    for (int i = 0; i < 13; i++) begin
      raw_in = tbl[i].raw;
      tick();
      tick();
      tick();
      check($sformatf("tbl%0d_vd", i), 32'(vd), 32'(tbl[i].vd));
      check($sformatf("tbl%0d_cd", i), 32'(cd), 32'(tbl[i].cd));
      check($sformatf("tbl%0d_vde", i), 32'(vde), 32'(tbl[i].vde));
    end

    // Aligned lock, then loss of lock on a data-only stream.
    do_reset(3, 0);
    run_to(9);
    check("align_locked_t9", 32'(locked), 0);
    run_to(10);
    check("align_locked_t10", 32'(locked), 1);
    run_to(12);
    check("align_tok_cd", 32'(cd), 0);
    check("align_tok_vde", 32'(vde), 0);
    run_to(19);
    check("align_data_vde", 32'(vde), 1);
    check("align_data_vd", 32'(vd), 8'h00);
    wait_locked(1'b0, 8400, "loss_locked");
    d = k_word - 16;
    n_vec++;
    if (d < 8190 || d > 8196) begin
      n_err++;
      $display("FAIL loss_timing: locked fell after %0d data words, required 8190..8196", d);
    end
    check("loss_offset", 32'(offset), 1);

    // Stream misaligned by 3 bits.
    do_reset(1, 3);
    run_to(4095);
    check("mis_off_t4095", 32'(offset), 0);
    run_to(4096);
    check("mis_off_t4096", 32'(offset), 1);
    run_to(8192);
    check("mis_off_t8192", 32'(offset), 2);
    run_to(12288);
    check("mis_off_t12288", 32'(offset), 3);
    check("mis_unlocked", 32'(locked), 0);
    wait_locked(1'b1, 3000, "mis_locked");
    check("mis_lock_offset", 32'(offset), 3);
    for (int i = 0; i < 5; i++) drive_tick();
    check("mis_blank_cd", 32'(cd), 1);
    check("mis_blank_vde", 32'(vde), 0);
    for (int i = 0; i < 250; i++) drive_tick();
    check("mis_data_vde", 32'(vde), 1);
    check("mis_data_vd", 32'(vd), 8'h11);

    // Offset wraps 9 -> 0 before locking on an aligned stream.
    do_reset(4, 0);
    run_to(36864);
    check("wrap_off9", 32'(offset), 9);
    run_to(40959);
    check("wrap_off9_hold", 32'(offset), 9);
    run_to(40960);
    check("wrap_off0", 32'(offset), 0);
    check("wrap_unlocked", 32'(locked), 0);
    wait_locked(1'b1, 1200, "wrap_locked");
    check("wrap_lock_offset", 32'(offset), 0);

    // Eighth token coincides with the search timeout; lock wins.
    do_reset(2, 0);
    run_to(4095);
    check("simul_unlocked", 32'(locked), 0);
    run_to(4096);
    check("simul_locked", 32'(locked), 1);
    check("simul_offset", 32'(offset), 0);
    run_to(4100);
    check("simul_cd", 32'(cd), 3);

    // Asynchronous reset while locked, between clock edges.
    #2;
    rst = 1'b1;
    #1;
    check("arst_vd", 32'(vd), 0);
    check("arst_cd", 32'(cd), 0);
    check("arst_vde", 32'(vde), 0);
    check("arst_locked", 32'(locked), 0);
    check("arst_offset", 32'(offset), 0);
    tick();
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
